// File: rtl/sram_test_pkg.sv
// sram_test_pkg: constants shared by the SRAM pattern tester and its address
// sequencer. Holds the FSM state encodings, the generator pattern-index width
// and the number of settle cycles after each generator edge.
package sram_test_pkg;

   localparam int PAT_IDX_W     = 3;
   localparam int SETTLE_CYCLES = 2;

   localparam logic [3:0] ST_IDLE      = 4'd0;
   localparam logic [3:0] ST_GEN_RESET = 4'd1;
   localparam logic [3:0] ST_SETTLE    = 4'd2;
   localparam logic [3:0] ST_WRITE     = 4'd3;
   localparam logic [3:0] ST_READ      = 4'd4;
   localparam logic [3:0] ST_READ_WAIT = 4'd5;
   localparam logic [3:0] ST_ADVANCE   = 4'd6;
   localparam logic [3:0] ST_DONE      = 4'd7;
   localparam logic [3:0] ST_FAIL      = 4'd8;

   typedef enum logic [3:0] {
      S_IDLE      = ST_IDLE,
      S_GEN_RESET = ST_GEN_RESET,
      S_SETTLE    = ST_SETTLE,
      S_WRITE     = ST_WRITE,
      S_READ      = ST_READ,
      S_READ_WAIT = ST_READ_WAIT,
      S_ADVANCE   = ST_ADVANCE,
      S_DONE      = ST_DONE,
      S_FAIL      = ST_FAIL
   } state_t;

endpackage

// File: rtl/sram_addr_sequencer.sv
// sram_addr_sequencer: address counter shared by the write and read sweeps.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   i_clr       - synchronous clear to 0 (has priority over i_inc)
//   i_inc       - advance by one
//   o_addr      - current address
//   o_last      - current address is the top of the range (all ones)
module sram_addr_sequencer #(
   parameter int ADDR_BITS = 20
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_clr,
   input  logic                 i_inc,
   output logic [ADDR_BITS-1:0] o_addr,
   output logic                 o_last
);

   logic [ADDR_BITS-1:0] r_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_addr <= '0;
      else if (i_clr) r_addr <= '0;
      else if (i_inc) r_addr <= r_addr + 1'b1;
   end

   assign o_addr = r_addr;
   // Explicit compare; the FSM never relies on the counter wrapping.
   assign o_last = (r_addr == {ADDR_BITS{1'b1}});

endmodule

// File: rtl/sram_pattern_tester.sv
// sram_pattern_tester: for each generator pattern, writes the whole SRAM
// address range, reads it back and compares. Halts on the first mismatch with
// diagnostics latched, otherwise advances the generator until done and
// reports pass.
// Ports:
//   clk, reset_n             - clock, async active-low reset (sync release)
//   start                    - run start pulse (ignored while busy)
//   pattern/_done/_state     - generator outputs
//   pattern_next/_reset      - registered one-cycle generator strobes
//   sram_req/ready/we/addr/wdata/rdata/rvalid - SRAM controller interface
//   busy, test_pass, test_fail - run status (pass/fail sticky)
//   fail_addr/expected/actual/pattern - first-mismatch diagnostics
// Build option: SRAM_PATTERN_TESTER_ADDR_MIX_EN XORs the address into the
// expected data so address aliasing and stuck address lines are caught.
module sram_pattern_tester
   import sram_test_pkg::*;
#(
   parameter int ADDR_BITS = 20,
   parameter int DATA_BITS = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [DATA_BITS-1:0] pattern,
   input  logic                 pattern_done,
   input  logic [PAT_IDX_W-1:0] pattern_state,
   output logic                 pattern_next,
   output logic                 pattern_reset,
   output logic                 sram_req,
   input  logic                 sram_ready,
   output logic                 sram_we,
   output logic [ADDR_BITS-1:0] sram_addr,
   output logic [DATA_BITS-1:0] sram_wdata,
   input  logic [DATA_BITS-1:0] sram_rdata,
   input  logic                 sram_rvalid,
   output logic                 busy,
   output logic                 test_pass,
   output logic                 test_fail,
   output logic [ADDR_BITS-1:0] fail_addr,
   output logic [DATA_BITS-1:0] fail_expected,
   output logic [DATA_BITS-1:0] fail_actual,
   output logic [PAT_IDX_W-1:0] fail_pattern
);

   // Reset asserts asynchronously everywhere but releases on a clock edge.
   logic [1:0] r_rst_sync;
   logic       w_rst_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_rst_sync <= 2'b00;
      else          r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   state_t               r_state, w_nxt;
   logic [1:0]           r_settle_cnt;
   logic                 w_addr_clr, w_addr_inc, w_last, w_hs, w_start_acc;
   logic [ADDR_BITS-1:0] w_addr;
   logic [DATA_BITS-1:0] w_expected;

   sram_addr_sequencer #(.ADDR_BITS(ADDR_BITS)) u_addr_seq (
      .clk    (clk),
      .rst_n  (w_rst_n),
      .i_clr  (w_addr_clr),
      .i_inc  (w_addr_inc),
      .o_addr (w_addr),
      .o_last (w_last)
   );

`ifdef SRAM_PATTERN_TESTER_ADDR_MIX_EN
   logic [DATA_BITS-1:0] w_addr_mix;
   if (ADDR_BITS >= DATA_BITS) begin : g_mix_trunc
      assign w_addr_mix = w_addr[DATA_BITS-1:0];
   end else begin : g_mix_zext
      assign w_addr_mix = {{(DATA_BITS-ADDR_BITS){1'b0}}, w_addr};
   end
   assign w_expected = pattern ^ w_addr_mix;
`else
   assign w_expected = pattern;
`endif

   assign sram_req   = (r_state == S_WRITE) || (r_state == S_READ);
   assign sram_we    = (r_state == S_WRITE);
   assign sram_addr  = w_addr;
   assign sram_wdata = (r_state == S_WRITE) ? w_expected : '0;
   assign w_hs       = sram_req && sram_ready;

   always_comb begin
      w_nxt       = r_state;
      w_addr_clr  = 1'b0;
      w_addr_inc  = 1'b0;
      w_start_acc = 1'b0;
      case (r_state)
         S_IDLE, S_DONE, S_FAIL: begin
            if (start) begin
               w_start_acc = 1'b1;
               w_nxt       = S_GEN_RESET;
            end
         end
         S_GEN_RESET: w_nxt = S_SETTLE;
         S_SETTLE: begin
            if (r_settle_cnt == 2'(SETTLE_CYCLES-1)) begin
               if (pattern_done) begin
                  w_nxt = S_DONE;
               end else begin
                  w_nxt      = S_WRITE;
                  w_addr_clr = 1'b1;
               end
            end
         end
         S_WRITE: begin
            if (w_hs) begin
               if (w_last) begin
                  w_nxt      = S_READ;
                  w_addr_clr = 1'b1;
               end else begin
                  w_addr_inc = 1'b1;
               end
            end
         end
         S_READ: if (w_hs) w_nxt = S_READ_WAIT;
         S_READ_WAIT: begin
            if (sram_rvalid) begin
               if (sram_rdata != w_expected) begin
                  w_nxt = S_FAIL;
               end else if (w_last) begin
                  w_nxt = S_ADVANCE;
               end else begin
                  w_nxt      = S_READ;
                  w_addr_inc = 1'b1;
               end
            end
         end
         S_ADVANCE: w_nxt = S_SETTLE;
         default:   w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state      <= S_IDLE;
         r_settle_cnt <= '0;
      end else begin
         r_state      <= w_nxt;
         r_settle_cnt <= (r_state == S_SETTLE) ? r_settle_cnt + 2'd1 : 2'd0;
      end
   end

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         pattern_next  <= 1'b0;
         pattern_reset <= 1'b0;
         busy          <= 1'b0;
         test_pass     <= 1'b0;
         test_fail     <= 1'b0;
         fail_addr     <= '0;
         fail_expected <= '0;
         fail_actual   <= '0;
         fail_pattern  <= '0;
      end else begin
         // Strobes are high during GEN_RESET / ADVANCE; generator moves on the
         // edge that leaves those states.
         pattern_reset <= w_start_acc;
         pattern_next  <= (w_nxt == S_ADVANCE);
         if (w_start_acc) begin
            busy          <= 1'b1;
            test_pass     <= 1'b0;
            test_fail     <= 1'b0;
            fail_addr     <= '0;
            fail_expected <= '0;
            fail_actual   <= '0;
            fail_pattern  <= '0;
         end else if (r_state == S_SETTLE && w_nxt == S_DONE) begin
            busy      <= 1'b0;
            test_pass <= 1'b1;
         end else if (r_state == S_READ_WAIT && w_nxt == S_FAIL) begin
            busy          <= 1'b0;
            test_fail     <= 1'b1;
            fail_addr     <= w_addr;
            fail_expected <= w_expected;
            fail_actual   <= sram_rdata;
            fail_pattern  <= pattern_state;
         end
      end
   end

endmodule

// File: tb/tb_sram_pattern_tester.sv
module tb_sram_pattern_tester;
   localparam int AB = 4;
   localparam int DB = 16;
   localparam logic [15:0] PAT [7] = '{16'h0000, 16'hFFFF, 16'hAAAA, 16'h5555,
                                       16'h00FF, 16'hFF00, 16'h0F0F};
   localparam logic [63:0] SENT = 64'h8000_0000_0000_0000;

   logic          clk = 1'b0, reset_n = 1'b1, start = 1'b0;
   logic [DB-1:0] pattern;
   logic          pattern_done;
   logic [2:0]    pattern_state;
   logic          pattern_next, pattern_reset, sram_req, sram_we;
   logic          sram_ready = 1'b1, sram_rvalid = 1'b0;
   logic [AB-1:0] sram_addr, fail_addr;
   logic [DB-1:0] sram_wdata, fail_expected, fail_actual;
   logic [DB-1:0] sram_rdata = '0;
   logic          busy, test_pass, test_fail;
   logic [2:0]    fail_pattern;

   always #5 clk = ~clk;

   sram_pattern_tester #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .pattern(pattern), .pattern_done(pattern_done), .pattern_state(pattern_state),
      .pattern_next(pattern_next), .pattern_reset(pattern_reset),
      .sram_req(sram_req), .sram_ready(sram_ready), .sram_we(sram_we),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
      .sram_rvalid(sram_rvalid), .busy(busy), .test_pass(test_pass),
      .test_fail(test_fail), .fail_addr(fail_addr), .fail_expected(fail_expected),
      .fail_actual(fail_actual), .fail_pattern(fail_pattern)
   );

   int n_pass = 0, n_total = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_of(input int p, input int a);
`ifdef SRAM_PATTERN_TESTER_ADDR_MIX_EN
      return PAT[p] ^ 16'(a);
`else
      return PAT[p] + 16'(a & 0);
`endif
   endfunction

   function automatic logic [63:0] mk(input logic we, input int a, input logic [15:0] d);
      return {16'h0, 7'h0, 1'b1, 7'h0, we, 12'h0, 4'(a), (we ? d : 16'h0)};
   endfunction

   // Pattern generator model: 7 patterns, done after the last.
   logic [3:0] gidx = 4'd0;
   assign pattern       = (gidx < 4'd7) ? PAT[gidx[2:0]] : 16'h0;
   assign pattern_done  = (gidx >= 4'd7);
   assign pattern_state = gidx[2:0];

   // SRAM model + scoreboard of expected requests.
   logic [15:0] mem [16];
   logic [63:0] sbq [$];
   logic [63:0] obs, hold_obs, exp_item;
   logic [15:0] rd_data;
   logic [3:0]  phys;
   bit  bp_en = 0, stuck_en = 0, alias_en = 0, rd_pend = 0, hold_v = 0;
   int  max_lat = 1, rd_cnt = 0, n_next = 0, n_reset = 0;

   always @(negedge clk) begin
      if (!reset_n) begin
         rd_pend     = 0;
         hold_v      = 0;
         sram_rvalid = 1'b0;
      end else begin
         if (pattern_reset) begin gidx = 4'd0; n_reset++; end
         else if (pattern_next) begin gidx = gidx + 4'd1; n_next++; end
         sram_rvalid = 1'b0;
         if (rd_pend) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
               sram_rvalid = 1'b1;
               sram_rdata  = rd_data;
               rd_pend     = 0;
            end
         end
         obs = {16'h0, 7'h0, sram_req, 7'h0, sram_we, 12'h0, sram_addr,
                (sram_we ? sram_wdata : 16'h0)};
         if (hold_v) chk("hold_stable", obs, hold_obs);
         hold_v = 0;
         sram_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
         if (sram_req && sram_ready) begin
            exp_item = (sbq.size() > 0) ? sbq.pop_front() : SENT;
            chk("req", obs, exp_item);
            phys = alias_en ? (sram_addr & 4'h7) : sram_addr;
            if (sram_we) mem[phys] = sram_wdata;
            else begin
               rd_pend = 1;
               rd_cnt  = $urandom_range(1, max_lat);
               rd_data = mem[phys];
               if (stuck_en && sram_addr == 4'd5) rd_data[3] = 1'b0;
            end
         end else if (sram_req) begin
            hold_v   = 1;
            hold_obs = obs;
         end
      end
   end

   task automatic push_pat(input int p, input int nrd);
      for (int a = 0; a < 16; a++) sbq.push_back(mk(1'b1, a, exp_of(p, a)));
      for (int a = 0; a < nrd; a++) sbq.push_back(mk(1'b0, a, 16'h0));
   endtask

   task automatic push_full();
      for (int p = 0; p < 7; p++) push_pat(p, 16);
   endtask

   task automatic pulse_start();
      @(negedge clk); #2 start = 1'b1;
      @(negedge clk); #2 start = 1'b0;
   endtask

   task automatic new_run();
      sbq.delete();
      n_next  = 0;
      n_reset = 0;
   endtask

   task automatic wait_idle(input string tag);
      int cyc = 0;
      while (busy && cyc < 20000) begin @(negedge clk); cyc++; end
      #2;
      chk({tag, "_busy_end"}, 64'(busy), 64'd0);
   endtask

   task automatic chk_end(input string tag, input logic p, input logic f);
      chk({tag, "_pass"},  64'(test_pass), 64'(p));
      chk({tag, "_fail"},  64'(test_fail), 64'(f));
      chk({tag, "_req"},   64'(sram_req), 64'd0);
      chk({tag, "_sb"},    64'(sbq.size()), 64'd0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, 64'({pattern_next, pattern_reset, sram_req, sram_we, sram_addr,
                              sram_wdata, busy, test_pass, test_fail}), 64'd0);
      chk({tag, "_diag"}, 64'({fail_addr, fail_expected, fail_actual, fail_pattern}), 64'd0);
   endtask

   initial begin
      bit found;
      for (int i = 0; i < 16; i++) mem[i] = 16'h0;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      #1 chk_zero("reset");
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

      // Ideal SRAM, 1-cycle latency.
      new_run(); push_full();
      pulse_start();
      chk("busy_after_start", 64'(busy), 64'd1);
      wait_idle("ideal");
      chk_end("ideal", 1'b1, 1'b0);
      chk("ideal_nexts", 64'(n_next), 64'd7);
      chk("ideal_resets", 64'(n_reset), 64'd1);

      // Stuck-at-0 on bit 3 at address 5.
      stuck_en = 1;
      new_run(); push_pat(0, 16); push_pat(1, 6);
      pulse_start();
      wait_idle("stuck");
      chk_end("stuck", 1'b0, 1'b1);
      chk("stuck_addr", 64'(fail_addr), 64'd5);
      chk("stuck_pat", 64'(fail_pattern), 64'd1);
      chk("stuck_exp", 64'(fail_expected), 64'(exp_of(1, 5)));
      chk("stuck_act", 64'(fail_actual), 64'(exp_of(1, 5) & 16'hFFF7));
      chk("stuck_nexts", 64'(n_next), 64'd1);
      stuck_en = 0;

      // Random backpressure and 1..4 cycle read latency.
      bp_en = 1; max_lat = 4;
      new_run(); push_full();
      pulse_start();
      wait_idle("bp");
      chk_end("bp", 1'b1, 1'b0);
      chk("bp_nexts", 64'(n_next), 64'd7);
      chk("bp_diag_clear", 64'({fail_addr, fail_expected, fail_actual, fail_pattern}), 64'd0);
      bp_en = 0; max_lat = 1;

      // start while busy is ignored.
      new_run(); push_full();
      pulse_start();
      repeat (50) @(negedge clk);
      pulse_start();
      wait_idle("busy_start");
      chk_end("busy_start", 1'b1, 1'b0);
      chk("busy_start_resets", 64'(n_reset), 64'd1);

      // Reset in the middle of the write phase of pattern 2.
      new_run(); push_full();
      pulse_start();
      found = 0;
      for (int c = 0; c < 5000 && !found; c++) begin
         @(negedge clk); #2;
         if (gidx == 4'd2 && sram_req && sram_we && sram_addr == 4'd7) found = 1;
      end
      chk("reach_pat2_write", 64'(found), 64'd1);
      reset_n = 1'b0;
      #1 chk_zero("midrun_reset");
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b1;
      repeat (4) @(negedge clk);
      new_run(); push_full();
      pulse_start();
      wait_idle("rerun");
      chk_end("rerun", 1'b1, 1'b0);
      chk("rerun_nexts", 64'(n_next), 64'd7);

`ifdef SRAM_PATTERN_TESTER_ADDR_MIX_EN
      // Address 8 aliases onto address 0.
      alias_en = 1;
      new_run(); push_pat(0, 1);
      pulse_start();
      wait_idle("alias");
      chk_end("alias", 1'b0, 1'b1);
      chk("alias_addr", 64'(fail_addr), 64'd0);
      chk("alias_pat", 64'(fail_pattern), 64'd0);
      chk("alias_exp", 64'(fail_expected), 64'h0000);
      chk("alias_act", 64'(fail_actual), 64'h0008);
      alias_en = 0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
